// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO/FIFO storage family: operation encoding
// and the occupancy-counter width helper.
package lifo_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  // Wide enough to hold 0..depth inclusive.
  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_regfile.sv
// WIDTH x DEPTH storage with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module lifo_regfile #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack: push/pop/swap with occupancy count, almost-full,
// sticky overflow/underflow and a one-cycle pop-valid strobe.
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       EN,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic                       CLR_ERR,
  input  logic [WIDTH-1:0]           dataIn,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       VALID,
  output logic [WIDTH-1:0]           TOP,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       AFULL,
  output logic                       OVF,
  output logic                       UDF
);

  localparam int CW = CNT_W(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]       op;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] rdata;

  assign op    = EN ? {POP, PUSH} : OP_NONE;
  assign EMPTY = (COUNT == CW'(0));
  assign FULL  = (COUNT == CW'(DEPTH));
  assign AFULL = (COUNT >= CW'(DEPTH - AF_MARGIN));

  // Parking the read index at 0 when empty keeps it inside the array.
  assign top_idx = EMPTY ? '0 : AW'(COUNT - CW'(1));
  assign TOP     = EMPTY ? '0 : rdata;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    case (op)
      OP_PUSH: begin
        we    = !FULL;
        waddr = AW'(COUNT);
      end
      OP_SWAP: begin
        we    = !EMPTY;
        waddr = top_idx;
      end
      default: ;
    endcase
  end

  lifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (Clk),
    .we    (we),
    .waddr (waddr),
    .wdata (dataIn),
    .raddr (top_idx),
    .rdata (rdata)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      COUNT   <= '0;
      dataOut <= '0;
      VALID   <= 1'b0;
      OVF     <= 1'b0;
      UDF     <= 1'b0;
    end else begin
      VALID <= 1'b0;
      // Clear first so an error raised on the same edge takes precedence.
      if (CLR_ERR) begin
        OVF <= 1'b0;
        UDF <= 1'b0;
      end
      case (op)
        OP_PUSH: begin
          if (FULL) OVF <= 1'b1;
          else      COUNT <= COUNT + CW'(1);
        end
        OP_POP: begin
          if (EMPTY) begin
            UDF <= 1'b1;
          end else begin
            dataOut <= rdata;
            COUNT   <= COUNT - CW'(1);
            VALID   <= 1'b1;
          end
        end
        OP_SWAP: begin
          dataOut <= EMPTY ? dataIn : rdata;
          VALID   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param at WIDTH=4, DEPTH=8, AF_MARGIN=2.
module tb_lifo_stack_param;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       EN, PUSH, POP, CLR_ERR;
  logic [3:0] dataIn;
  logic [3:0] dataOut, TOP;
  logic [3:0] COUNT;
  logic       VALID, EMPTY, FULL, AFULL, OVF, UDF;

  int checks   = 0;
  int failures = 0;

  lifo_stack_param #(.WIDTH(4), .DEPTH(8), .AF_MARGIN(2)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .EN      (EN),
    .PUSH    (PUSH),
    .POP     (POP),
    .CLR_ERR (CLR_ERR),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .VALID   (VALID),
    .TOP     (TOP),
    .COUNT   (COUNT),
    .EMPTY   (EMPTY),
    .FULL    (FULL),
    .AFULL   (AFULL),
    .OVF     (OVF),
    .UDF     (UDF)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let it be sampled, then settle before checking.
  task automatic do_op(input logic en, input logic push, input logic pop,
                       input logic clr, input logic [3:0] din);
    EN = en; PUSH = push; POP = pop; CLR_ERR = clr; dataIn = din;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; EN = 1'b0; PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0; dataIn = 4'h0;
    #3;
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full",  32'(FULL),  32'd0);
    check("rst_afull", 32'(AFULL), 32'd0);
    check("rst_top",   32'(TOP),   32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_dout",  32'(dataOut), 32'd0);
    check("rst_errs",  32'({OVF, UDF}), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Build some state, then reset in the middle of a push.
    do_op(1, 1, 0, 0, 4'h5);
    do_op(1, 1, 0, 0, 4'h6);
    check("pre_count", 32'(COUNT), 32'd2);
    do_op(1, 0, 1, 0, 4'h0);
    check("pre_pop_dout",  32'(dataOut), 32'h6);
    check("pre_pop_valid", 32'(VALID), 32'd1);
    do_op(1, 0, 1, 0, 4'h0);
    do_op(1, 0, 1, 0, 4'h0);
    check("pre_udf", 32'(UDF), 32'd1);
    check("pre_dout_hold", 32'(dataOut), 32'h5);
    EN = 1'b1; PUSH = 1'b1; POP = 1'b0; dataIn = 4'h7;
    #2;
    Rst = 1'b0;
    #1;
    check("midrst_count", 32'(COUNT), 32'd0);
    check("midrst_empty", 32'(EMPTY), 32'd1);
    check("midrst_dout",  32'(dataOut), 32'd0);
    check("midrst_errs",  32'({OVF, UDF}), 32'd0);
    @(posedge Clk);
    #1;
    check("midrst_push_lost", 32'(COUNT), 32'd0);
    PUSH = 1'b0; EN = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;

    // Fill to full.
    for (int i = 1; i <= 8; i++) begin
      do_op(1, 1, 0, 0, 4'(i));
      check("fill_count", 32'(COUNT), 32'(i));
      check("fill_top",   32'(TOP),   32'(i));
      check("fill_afull", 32'(AFULL), (i >= 6) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(FULL), 32'd1);
    do_op(1, 1, 0, 0, 4'hF);
    check("ovf_count", 32'(COUNT), 32'd8);
    check("ovf_flag",  32'(OVF),   32'd1);
    check("ovf_top",   32'(TOP),   32'h8);

    // Error clear, then clear colliding with a new overflow.
    do_op(1, 0, 0, 1, 4'h0);
    check("clr_ovf", 32'(OVF), 32'd0);
    do_op(1, 1, 0, 1, 4'hE);
    check("clr_vs_set_ovf", 32'(OVF), 32'd1);
    check("clr_vs_set_count", 32'(COUNT), 32'd8);
    do_op(1, 0, 0, 1, 4'h0);
    check("clr_ovf2", 32'(OVF), 32'd0);

    // Drain.
    for (int i = 1; i <= 8; i++) begin
      do_op(1, 0, 1, 0, 4'h0);
      check("drain_dout",  32'(dataOut), 32'(9 - i));
      check("drain_valid", 32'(VALID),   32'd1);
      check("drain_count", 32'(COUNT),   32'(8 - i));
    end
    check("drain_empty", 32'(EMPTY), 32'd1);
    check("drain_top",   32'(TOP),   32'd0);
    do_op(1, 0, 1, 0, 4'h0);
    check("udf_flag",  32'(UDF),     32'd1);
    check("udf_dout",  32'(dataOut), 32'h1);
    check("udf_valid", 32'(VALID),   32'd0);
    do_op(1, 0, 0, 1, 4'h0);
    check("clr_udf", 32'(UDF), 32'd0);

    // Swap on a two-entry stack.
    do_op(1, 1, 0, 0, 4'h3);
    do_op(1, 1, 0, 0, 4'h5);
    do_op(1, 1, 1, 0, 4'h9);
    check("swap_dout",  32'(dataOut), 32'h5);
    check("swap_valid", 32'(VALID),   32'd1);
    check("swap_top",   32'(TOP),     32'h9);
    check("swap_count", 32'(COUNT),   32'd2);
    check("swap_errs",  32'({OVF, UDF}), 32'd0);

    // Disabled ops are ignored.
    do_op(0, 1, 0, 0, 4'hB);
    do_op(0, 0, 1, 0, 4'hC);
    do_op(0, 1, 1, 0, 4'hD);
    check("en0_count", 32'(COUNT),   32'd2);
    check("en0_dout",  32'(dataOut), 32'h5);
    check("en0_top",   32'(TOP),     32'h9);
    check("en0_valid", 32'(VALID),   32'd0);
    check("en0_errs",  32'({OVF, UDF}), 32'd0);

    do_op(1, 0, 1, 0, 4'h0);
    check("post_swap_pop1", 32'(dataOut), 32'h9);
    do_op(1, 0, 1, 0, 4'h0);
    check("post_swap_pop2", 32'(dataOut), 32'h3);
    check("post_swap_empty", 32'(EMPTY), 32'd1);

    // Bypass on an empty stack.
    do_op(1, 1, 1, 0, 4'hA);
    check("byp_dout",  32'(dataOut), 32'hA);
    check("byp_valid", 32'(VALID),   32'd1);
    check("byp_count", 32'(COUNT),   32'd0);
    check("byp_errs",  32'({OVF, UDF}), 32'd0);
    do_op(1, 0, 0, 0, 4'h0);
    check("idle_valid", 32'(VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
